// File: rtl/sump_pkg.sv
// Shared SUMP protocol definitions: opcode constants, the decoder state type
// and the short-command strobe decode used by the command framer.
package sump_pkg;

    localparam logic [7:0] OP_RESET       = 8'h00;
    localparam logic [7:0] OP_RUN         = 8'h01;
    localparam logic [7:0] OP_ID          = 8'h02;
    localparam logic [7:0] OP_META        = 8'h04;
    localparam logic [7:0] OP_XON         = 8'h11;
    localparam logic [7:0] OP_XOFF        = 8'h13;
    localparam logic [7:0] OP_DIVIDER     = 8'h80;
    localparam logic [7:0] OP_COUNT       = 8'h81;
    localparam logic [7:0] OP_FLAGS       = 8'h82;
    localparam logic [7:0] OP_TRIG_MASK   = 8'hC0;
    localparam logic [7:0] OP_TRIG_VALUE  = 8'hC1;
    localparam logic [7:0] OP_TRIG_CONFIG = 8'hC2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ARG  = 1'b1
    } cmd_state_t;

    typedef struct packed {
        logic reset;
        logic run;
        logic id;
        logic meta;
        logic xon;
        logic xoff;
    } op_strobe_t;

    // One-hot decode of the common short commands; anything else yields all zero.
    function automatic op_strobe_t decode_short(input logic [7:0] op);
        op_strobe_t s;
        s = 6'b000000;
        case (op)
            OP_RESET: s.reset = 1'b1;
            OP_RUN:   s.run   = 1'b1;
            OP_ID:    s.id    = 1'b1;
            OP_META:  s.meta  = 1'b1;
            OP_XON:   s.xon   = 1'b1;
            OP_XOFF:  s.xoff  = 1'b1;
            default:  s       = 6'b000000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sump_cmd_decoder.sv
// SUMP byte-stream framer: classifies opcodes as 1-byte or 5-byte commands and
// emits one registered strobe per complete command, with an idle-timeout abort.
module sump_cmd_decoder
    import sump_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        cmd_valid,
    output logic        cmd_long,
    output logic [7:0]  opcode,
    output logic [31:0] data,
    output logic        op_reset,
    output logic        op_run,
    output logic        op_id,
    output logic        op_meta,
    output logic        op_xon,
    output logic        op_xoff,
    output logic        cmd_abort
);

    // A zero timeout still needs a legal one-bit counter even though it is never used.
    localparam int              CNT_W      = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam bit              TIMEOUT_EN = (IDLE_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LAST  = TIMEOUT_EN ? CNT_W'(IDLE_TIMEOUT - 1) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    cmd_state_t       state_r;
    cmd_state_t       state_nxt_s;
    logic [1:0]       idx_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       shadow_op_r;
    logic [31:0]      shadow_data_r;
    logic             timeout_s;

    logic             cmd_valid_s;
    logic             cmd_long_s;
    logic             abort_s;
    logic [7:0]       opcode_s;
    logic [31:0]      data_s;
    op_strobe_t       strobe_s;

    // An arriving byte always beats expiry, so rx_valid suppresses the timeout.
    assign timeout_s = TIMEOUT_EN && (state_r == ARG) && !rx_valid && (cnt_r == CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (rx_valid && rx_data[7]) begin
                    state_nxt_s = ARG;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ARG: begin
                if (rx_valid) begin
                    state_nxt_s = (idx_r == 2'd3) ? IDLE : ARG;
                end else if (timeout_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ARG;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode: next values of the registered command outputs.
    always_comb begin
        cmd_valid_s = 1'b0;
        cmd_long_s  = 1'b0;
        abort_s     = 1'b0;
        opcode_s    = opcode;
        data_s      = data;
        case (state_r)
            IDLE: begin
                if (rx_valid && !rx_data[7]) begin
                    cmd_valid_s = 1'b1;
                    opcode_s    = rx_data;
                end else begin
                    cmd_valid_s = 1'b0;
                end
            end
            ARG: begin
                if (rx_valid && (idx_r == 2'd3)) begin
                    cmd_valid_s = 1'b1;
                    cmd_long_s  = 1'b1;
                    opcode_s    = shadow_op_r;
                    data_s      = {rx_data, shadow_data_r[23:0]};
                end else if (timeout_s) begin
                    abort_s = 1'b1;
                end else begin
                    cmd_valid_s = 1'b0;
                end
            end
            default: begin
                cmd_valid_s = 1'b0;
            end
        endcase
        if (cmd_valid_s) begin
            strobe_s = decode_short(opcode_s);
        end else begin
            strobe_s = 6'b000000;
        end
    end

    // Idle counter: runs only while collecting arguments, saturating rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (rx_valid || (state_r != ARG) || timeout_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Shadow opcode/argument capture for long commands.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_op_r   <= 8'h00;
            shadow_data_r <= 32'h0000_0000;
            idx_r         <= 2'd0;
        end else if ((state_r == IDLE) && rx_valid && rx_data[7]) begin
            shadow_op_r   <= rx_data;
            shadow_data_r <= 32'h0000_0000;
            idx_r         <= 2'd0;
        end else if ((state_r == ARG) && rx_valid) begin
            shadow_data_r[{idx_r, 3'b000} +: 8] <= rx_data;
            idx_r                               <= idx_r + 2'd1;
        end else if (timeout_s) begin
            shadow_op_r   <= 8'h00;
            shadow_data_r <= 32'h0000_0000;
            idx_r         <= 2'd0;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Registered command outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd_long  <= 1'b0;
            cmd_abort <= 1'b0;
            opcode    <= 8'h00;
            data      <= 32'h0000_0000;
            op_reset  <= 1'b0;
            op_run    <= 1'b0;
            op_id     <= 1'b0;
            op_meta   <= 1'b0;
            op_xon    <= 1'b0;
            op_xoff   <= 1'b0;
        end else begin
            cmd_valid <= cmd_valid_s;
            cmd_long  <= cmd_long_s;
            cmd_abort <= abort_s;
            opcode    <= opcode_s;
            data      <= data_s;
            op_reset  <= strobe_s.reset;
            op_run    <= strobe_s.run;
            op_id     <= strobe_s.id;
            op_meta   <= strobe_s.meta;
            op_xon    <= strobe_s.xon;
            op_xoff   <= strobe_s.xoff;
        end
    end

endmodule

// File: doc/sump_cmd_decoder.md
# sump_cmd_decoder

Byte-to-command framer for the SUMP protocol. It sits directly downstream of the UART receiver and upstream of the sampler/trigger/control registers in the logic-sniffer top level. It consumes the raw received byte stream and classifies each opcode: bit 7 clear means a 1-byte short command, bit 7 set means a 5-byte long command. It emits one registered command strobe per complete command, carrying the opcode, a little-endian 32-bit argument and decoded one-hot strobes for the common short commands.

## Interface
Parameters:
- IDLE_TIMEOUT, 65536: clk cycles without a byte before a partial long command is abandoned; 0 disables the timeout.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  single-cycle strobe; rx_data is valid this cycle.
- cmd_valid  out  1  single-cycle strobe; a command is complete.
- cmd_long  out  1  qualifies cmd_valid; 1 means a 5-byte command.
- opcode  out  8  command opcode; held until the next cmd_valid.
- data  out  32  long-command argument; first argument byte maps to [7:0]; held until the next cmd_valid.
- op_reset, op_run, op_id, op_meta, op_xon, op_xoff  out  1 each  one-hot strobes, coincident with cmd_valid, for opcodes 0x00, 0x01, 0x02, 0x04, 0x11, 0x13.
- cmd_abort  out  1  single-cycle strobe; a partial long command was dropped by timeout.

## Operation
- States: IDLE and ARG. ARG carries a 2-bit argument index, 0..3.
- IDLE, on rx_valid:
  - rx_data[7] = 0: latch opcode, pulse cmd_valid with cmd_long = 0 and the matching op_* strobe (if any), stay in IDLE. data is left unchanged.
  - rx_data[7] = 1: latch opcode into a shadow register, clear index, go to ARG. No output strobe.
- ARG, on rx_valid:
  - Write the byte into shadow argument lane [index*8 +: 8], then increment index.
  - On index 3, copy shadow opcode and argument to opcode/data, pulse cmd_valid with cmd_long = 1, return to IDLE.
  - Every byte in ARG is argument data, including 0x00 and bytes with bit 7 set. Five consecutive 0x00 bytes therefore always resynchronise the decoder and end with a reset strobe.
- Timeout:
  - An idle counter clears on every rx_valid and counts only while in ARG.
  - When it reaches IDLE_TIMEOUT-1 with no rx_valid that cycle: pulse cmd_abort, discard the shadow registers, go to IDLE.
  - opcode/data keep the last completed command.
- Unknown opcodes are still framed and strobed, with all op_* low; downstream ignores them.
- No backpressure: the downstream logic must accept every cmd_valid. The UART byte rate guarantees at least one idle cycle between rx_valid strobes; back-to-back rx_valid is nevertheless handled one byte per cycle.

## Timing
- Reset values: cmd_valid, cmd_long, cmd_abort and all op_* = 0; opcode = 0x00; data = 0x00000000; state IDLE; index 0; timeout counter 0.
- Latency: cmd_valid rises one clk after the rx_valid of the last byte of a command. Outputs are registered; there is no combinational path from rx_* to any output.
- Simultaneous timeout expiry and rx_valid: the byte wins. It is taken as an argument byte and the counter clears.
- rst asserted mid-command: the partial command is lost with no abort strobe, and the next byte is treated as an opcode.
- Timeout counter width is $clog2(IDLE_TIMEOUT+1). It saturates and never wraps.

## Structure
- Shared package sump_pkg holds:
  - opcode constants: OP_RESET 8'h00, OP_RUN 8'h01, OP_ID 8'h02, OP_META 8'h04, OP_XON 8'h11, OP_XOFF 8'h13, OP_DIVIDER 8'h80, OP_COUNT 8'h81, OP_FLAGS 8'h82, OP_TRIG_MASK 8'hC0, OP_TRIG_VALUE 8'hC1, OP_TRIG_CONFIG 8'hC2;
  - the state enum, cmd_state_t {IDLE, ARG}.
- No sub-module. The timeout counter and the shadow registers are inline.

## Test plan
- Five bytes of 0x00 after reset: exactly one cmd_valid with opcode 0x00, cmd_long = 0, op_reset, for each byte. Five strobes in total, and the decoder ends in IDLE.
- Bytes 0x82, 0x00, 0x08, 0x00, 0x00: one cmd_valid, cmd_long = 1, opcode 0x82, data 0x00000800, no op_* strobes, one clk after the fifth rx_valid.
- Bytes 0xC2, 0x00, 0x00, 0x00, 0x08, then 0x02: long command with data 0x08000000, then a short cmd_valid with op_id.
- Bytes 0x81, 0x04, 0x00, then silence for IDLE_TIMEOUT cycles: cmd_abort pulses once with no cmd_valid. A following 0x01 produces op_run; opcode/data still show the previous command until then.
- rst asserted after 0x80 and two argument bytes, then 0x02 sent: op_id strobe and no cmd_abort.
- Argument byte arriving in the exact timeout-expiry cycle: no cmd_abort, and the command completes normally after the remaining bytes.
